// File: rtl/spi_flash_responder.sv
// SPI flash read-only responder (mode 0): READ (0x03) and JEDEC ID (0x9F)
// from a preloadable byte memory, oversampled in the clk domain.
module spi_flash_responder #(
  parameter int          DEPTH    = 256,
  parameter int          AW       = 8,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flash_csb,
  input  logic          flash_clk,
  input  logic          flash_io0_di,
  output logic          flash_io1_do,
  output logic          flash_io1_oe,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [7:0]    mem_wdata,
  output logic          busy,
  output logic [15:0]   rd_count
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, IGNORE} state_t;

  localparam int SW = (AW > 8) ? AW : 8;

  state_t        state_reg, state_next;
  logic [1:0]    csb_sync, sck_sync, mosi_sync;
  logic          csb_prev, sck_prev;
  logic [1:0]    valid_reg;
  logic          armed_reg;
  logic [4:0]    bit_cnt;
  logic [2:0]    out_cnt;
  logic          load_pending;
  logic [SW-2:0] shift_in;
  logic [SW-1:0] in_word;
  logic [23:0]   shift_out;
  logic [AW-1:0] addr_reg;
  logic [7:0]    rdata_reg;
  logic [7:0]    mem [DEPTH];

  logic csb_s, sck_s, mosi;
  logic csb_fall, csb_rise, sck_rise, sck_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      csb_sync  <= 2'b11;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      csb_prev  <= 1'b1;
      sck_prev  <= 1'b0;
      valid_reg <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      csb_sync  <= {csb_sync[0], flash_csb};
      sck_sync  <= {sck_sync[0], flash_clk};
      mosi_sync <= {mosi_sync[0], flash_io0_di};
      csb_prev  <= csb_sync[1];
      sck_prev  <= sck_sync[1];
      valid_reg <= {valid_reg[0], 1'b1};
      // Only a csb that has been seen high since reset may start a transaction.
      if (valid_reg[1] && csb_sync[1])
        armed_reg <= 1'b1;
    end
  end

  assign csb_s    = csb_sync[1];
  assign sck_s    = sck_sync[1];
  assign mosi     = mosi_sync[1];
  assign csb_fall = armed_reg & csb_prev & ~csb_s;
  assign csb_rise = ~csb_prev & csb_s;
  assign sck_rise = ~csb_rise & ~sck_prev & sck_s;
  assign sck_fall = ~csb_rise & sck_prev & ~sck_s;
  assign in_word  = {shift_in, mosi};

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (csb_fall) state_next = CMD;
      CMD:
        if (sck_rise && bit_cnt == 5'd7) begin
          case (in_word[7:0])
            8'h03:   state_next = ADDR;
            8'h9F:   state_next = ID;
            default: state_next = IGNORE;
          endcase
        end
      ADDR:   if (sck_fall && bit_cnt == 5'd24) state_next = DATA;
      default: state_next = state_reg;
    endcase
    if (csb_rise)
      state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      out_cnt      <= '0;
      load_pending <= 1'b0;
      shift_in     <= '0;
      shift_out    <= '0;
      addr_reg     <= '0;
      rd_count     <= '0;
    end else begin
      case (state_reg)
        IDLE:
          if (csb_fall) begin
            bit_cnt      <= '0;
            shift_out    <= '0;
            load_pending <= 1'b0;
          end
        CMD:
          if (sck_rise) begin
            shift_in <= in_word[SW-2:0];
            if (bit_cnt == 5'd7) begin
              bit_cnt      <= '0;
              load_pending <= (in_word[7:0] == 8'h9F);
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        ADDR: begin
          if (sck_rise && bit_cnt != 5'd24) begin
            shift_in <= in_word[SW-2:0];
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23)
              addr_reg <= in_word[AW-1:0];
          end
          // rdata_reg already holds mem[addr_reg] by the time this edge arrives.
          if (sck_fall && bit_cnt == 5'd24) begin
            shift_out <= {rdata_reg, 16'h0000};
            addr_reg  <= addr_reg + 1'b1;
            out_cnt   <= '0;
          end
        end
        DATA:
          if (sck_fall) begin
            if (out_cnt == 3'd7) begin
              shift_out <= {rdata_reg, 16'h0000};
              addr_reg  <= addr_reg + 1'b1;
              out_cnt   <= '0;
              if (rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
            end else begin
              shift_out <= {shift_out[22:0], 1'b0};
              out_cnt   <= out_cnt + 3'd1;
            end
          end
        ID:
          if (sck_fall) begin
            if (load_pending) begin
              shift_out    <= JEDEC_ID;
              load_pending <= 1'b0;
              out_cnt      <= '0;
            end else begin
              shift_out <= {shift_out[22:0], 1'b0};
              out_cnt   <= out_cnt + 3'd1;
              if (out_cnt == 3'd7 && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
            end
          end
        default: ;
      endcase
    end
  end

  // Memory is never reset; the read port always prefetches the next byte.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
    rdata_reg <= mem[addr_reg];
  end

  assign flash_io1_oe = (state_reg == DATA) || (state_reg == ID);
  assign flash_io1_do = flash_io1_oe & shift_out[23];
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed + randomized bench for spi_flash_responder: a host task drives
// mode-0 SPI and a byte-array model predicts read data, ID and rd_count.
module tb_spi_flash_responder;

  localparam logic [23:0] JEDEC = 24'hEF4016;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flash_csb = 1'b1;
  logic        flash_clk = 1'b0;
  logic        flash_io0_di = 1'b0;
  logic        flash_io1_do;
  logic        flash_io1_oe;
  logic        mem_we = 1'b0;
  logic [7:0]  mem_waddr = '0;
  logic [7:0]  mem_wdata = '0;
  logic        busy;
  logic [15:0] rd_count;

  int errors = 0;
  int checks = 0;
  int exp_rd_count = 0;
  logic [7:0] model [256];

  spi_flash_responder #(.DEPTH(256), .AW(8), .JEDEC_ID(JEDEC)) dut (
    .clk(clk), .rst(rst),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0_di(flash_io0_di),
    .flash_io1_do(flash_io1_do), .flash_io1_oe(flash_io1_oe),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [7:0] d);
    mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
    wait_clk(1);
    mem_we = 1'b0;
    model[a] = d;
  endtask

  // One SCK period: host samples MISO just before raising SCK.
  task automatic spi_bit(input logic mosi, output logic miso, output logic oe);
    flash_io0_di = mosi;
    wait_clk(5);
    miso = flash_io1_do;
    oe   = flash_io1_oe;
    flash_clk = 1'b1;
    wait_clk(5);
    flash_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, output logic oe_any);
    logic m, o;
    oe_any = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(bits[i], m, o);
      oe_any |= o;
    end
  endtask

  task automatic recv(input int n, output logic [63:0] data, output logic oe_all, output logic oe_any);
    logic m, o;
    data = '0; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi_bit(1'b0, m, o);
      data   = {data[62:0], m};
      oe_all &= o;
      oe_any |= o;
    end
  endtask

  task automatic cs_begin();
    flash_csb = 1'b0;
    wait_clk(5);
  endtask

  task automatic cs_end();
    wait_clk(2);
    flash_csb = 1'b1;
    wait_clk(6);
  endtask

  task automatic do_read(input logic [23:0] addr, input int nbytes, input string tag);
    logic [63:0] data, exp_data;
    logic oe_hdr, oe_all, oe_any;
    logic [7:0] a;
    exp_data = '0;
    for (int k = 0; k < nbytes; k++) begin
      a = addr[7:0] + 8'(k);
      exp_data = {exp_data[55:0], model[a]};
    end
    cs_begin();
    send_bits({8'h03, addr}, 32, oe_hdr);
    recv(nbytes * 8, data, oe_all, oe_any);
    cs_end();
    exp_rd_count += nbytes;
    check({tag, "_hdr_oe"}, 64'(oe_hdr), 64'd0);
    check({tag, "_data"}, data, exp_data);
    check({tag, "_data_oe"}, 64'(oe_all), 64'd1);
    check({tag, "_rd_count"}, 64'(rd_count), 64'(exp_rd_count));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    $display("read addr=%06h bytes=%0d data=%0h", addr, nbytes, data);
  endtask

  task automatic do_id(input int nbytes);
    logic [63:0] data, exp_data;
    logic oe_hdr, oe_all, oe_any;
    exp_data = '0;
    for (int k = 0; k < nbytes; k++)
      exp_data = {exp_data[55:0], (k < 3) ? JEDEC[23 - 8*k -: 8] : 8'h00};
    cs_begin();
    send_bits(32'h9F, 8, oe_hdr);
    recv(nbytes * 8, data, oe_all, oe_any);
    cs_end();
    exp_rd_count += nbytes;
    check("id_hdr_oe", 64'(oe_hdr), 64'd0);
    check("id_data", data, exp_data);
    check("id_data_oe", 64'(oe_all), 64'd1);
    check("id_rd_count", 64'(rd_count), 64'(exp_rd_count));
    $display("jedec id bytes=%0d data=%0h", nbytes, data);
  endtask

  task automatic do_ignore(input logic [7:0] cmd, input int nbits);
    logic [63:0] data;
    logic oe_hdr, oe_all, oe_any;
    cs_begin();
    send_bits(32'(cmd), 8, oe_hdr);
    recv(nbits, data, oe_all, oe_any);
    check("ign_oe", 64'(oe_hdr | oe_any), 64'd0);
    check("ign_do", data, 64'd0);
    check("ign_busy_sel", 64'(busy), 64'd1);
    cs_end();
    check("ign_busy_end", 64'(busy), 64'd0);
    check("ign_rd_count", 64'(rd_count), 64'(exp_rd_count));
    $display("ignored cmd=%02h bits=%0d", cmd, nbits);
  endtask

  initial begin
    logic [63:0] data;
    logic oe_hdr, oe_all, oe_any;
    logic [7:0] cmd;

    // Reset state
    wait_clk(4);
    check("rst_oe", 64'(flash_io1_oe), 64'd0);
    check("rst_do", 64'(flash_io1_do), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_count", 64'(rd_count), 64'd0);
    rst = 1'b0;
    wait_clk(2);

    for (int i = 0; i < 256; i++)
      mem_write(8'(i), 8'($urandom_range(0, 255)));

    // Basic read of four bytes
    mem_write(8'h10, 8'hA5); mem_write(8'h11, 8'h3C);
    mem_write(8'h12, 8'h00); mem_write(8'h13, 8'hFF);
    do_read(24'h000010, 4, "read4");

    // Wrap-around at the top of memory
    mem_write(8'hFF, 8'h11); mem_write(8'h00, 8'h22);
    do_read(24'h0000FF, 2, "wrap");

    do_id(4);

    do_ignore(8'hAB, 16);

    // Abort mid-address, then a clean read from 0
    cs_begin();
    send_bits({8'h03, 12'h5A5}, 20, oe_hdr);
    cs_end();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_oe", 64'(oe_hdr), 64'd0);
    $display("aborted read after 12 address bits");
    do_read(24'h000000, 2, "post_abort");

    // Reset during DATA after three bits
    mem_write(8'h40, 8'hC3); mem_write(8'h41, 8'h96);
    cs_begin();
    send_bits({8'h03, 24'h000040}, 32, oe_hdr);
    recv(3, data, oe_all, oe_any);
    check("pre_rst_bits", data, 64'(3'b110));
    rst = 1'b1;
    wait_clk(1);
    exp_rd_count = 0;
    check("mid_rst_oe", 64'(flash_io1_oe), 64'd0);
    check("mid_rst_rd_count", 64'(rd_count), 64'd0);
    rst = 1'b0;
    recv(16, data, oe_all, oe_any);
    check("post_rst_oe", 64'(oe_any), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    cs_end();
    $display("reset during data, csb held low for 16 bits");
    do_read(24'h000040, 2, "post_rst");

    // Randomized reads (upper address bits ignored) and unknown commands
    for (int t = 0; t < 5; t++)
      do_read(24'($urandom), $urandom_range(1, 6), "rand_read");
    for (int t = 0; t < 2; t++) begin
      cmd = 8'($urandom_range(0, 255));
      if (cmd == 8'h03 || cmd == 8'h9F)
        cmd = 8'h5A;
      do_ignore(cmd, $urandom_range(8, 24));
    end
    do_id(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter DEPTH, default 256; number of bytes in the internal memory, a power of two.
REQ-002 Parameter AW, default 8; memory address width, equal to log2(DEPTH).
REQ-003 Parameter JEDEC_ID, default 24'hEF4016; three-byte ID returned by command 0x9F, sent MSB byte first.
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 flash_csb  input  1  chip select from the host, active-low.
REQ-007 flash_clk  input  1  SPI clock from the host, mode 0 (idles low).
REQ-008 flash_io0_di  input  1  serial data from the host (MOSI).
REQ-009 flash_io1_do  output  1  serial data to the host (MISO).
REQ-010 flash_io1_oe  output  1  output enable for flash_io1_do.
REQ-011 mem_we  input  1  preload write strobe.
REQ-012 mem_waddr  input  AW  preload byte address.
REQ-013 mem_wdata  input  8  preload byte.
REQ-014 busy  output  1  high while a transaction is selected (any state other than IDLE).
REQ-015 rd_count  output  16  count of data bytes fully shifted out since reset; saturates at 16'hFFFF.

Function
REQ-016 flash_csb, flash_clk and flash_io0_di SHALL each pass through a 2-flop synchronizer into clk; all edge detection SHALL use the synchronized signals.
REQ-017 The host SHALL keep the flash_clk high and low phases at least 4 clk cycles each; behaviour is undefined for faster flash_clk.
REQ-018 On an SCK rising edge: MOSI SHALL be sampled, MSB first. On an SCK falling edge: MISO SHALL shift, MSB first.
REQ-019 The state machine SHALL have states IDLE, CMD, ADDR, DATA, ID and IGNORE.
REQ-020 A synchronized falling edge of csb SHALL move the FSM from IDLE to CMD and clear the bit counter.
REQ-021 CMD SHALL collect 8 bits, then branch on the command byte:
 - 0x03 goes to ADDR.
 - 0x9F goes to ID.
 - Any other value goes to IGNORE.
REQ-022 ADDR SHALL collect 24 bits; the effective address SHALL be the low AW bits (address modulo DEPTH).
REQ-023 On the SCK falling edge after the last address bit, the FSM SHALL enter DATA and drive bit 7 of mem[addr].
REQ-024 In DATA, after each 8th falling-edge shift, the address SHALL increment modulo DEPTH and the next byte SHALL load without a gap; the transfer continues indefinitely.
REQ-025 rd_count SHALL increment once per completed byte, in DATA or ID.
REQ-026 ID SHALL shift out JEDEC_ID (24 bits) starting on the first falling edge after the command byte; further bits SHALL be 0.
REQ-027 flash_io1_oe SHALL be 1 only in DATA and ID; otherwise oe=0 and do=0.
REQ-028 IGNORE SHALL hold oe=0 until csb deasserts.
REQ-029 A synchronized rising edge of csb in any state SHALL return the FSM to IDLE within 1 clk, drop oe and discard partial bytes; this includes aborts mid-command or mid-address.
REQ-030 An SCK edge in the same clk cycle as a csb rising edge SHALL be ignored.
REQ-031 mem_we SHALL write mem[mem_waddr] at the next clk edge.
REQ-032 If mem_we is active during DATA, it SHALL take effect, but a byte already loaded into the shifter SHALL not change.
REQ-033 busy SHALL equal (state != IDLE).

Reset
REQ-034 While rst is high, the FSM SHALL be IDLE; flash_io1_oe, flash_io1_do, busy and rd_count SHALL be 0; the synchronizers SHALL be set to csb=1 and sck=0.
REQ-035 Memory contents SHALL not be cleared by rst.
REQ-036 rst asserted mid-transaction SHALL abort it.
REQ-037 After rst releases, the block SHALL wait for a fresh csb falling edge; a still-low csb SHALL NOT start a transaction.

Verification
REQ-038 Preload mem[0x10..0x13] = A5,3C,00,FF; send 03 00 00 10 and clock 32 bits -> MISO A5 3C 00 FF; rd_count = 4.
REQ-039 Preload mem[0xFF] = 11 and mem[0x00] = 22; read from address 0x0000FF for 16 bits -> 11 then 22 (wrap-around).
REQ-040 Send 9F and clock 32 bits -> EF 40 16 00; oe high only after the command byte.
REQ-041 Send an unknown command 0xAB and clock 16 bits -> oe stays 0; busy stays 1 until csb rises, then 0.
REQ-042 Raise csb after 12 address bits, then issue 03 00 00 00 -> correct mem[0] data, with no stale state.
REQ-043 Assert rst during DATA after 3 bits -> oe=0 and rd_count=0 next cycle; with csb still low, no output appears until csb toggles.
